// File: rtl/despachador_minero.sv
// despachador_minero: job dispatcher in front of the modulo_area miner.
// Host jobs (96-bit block + 8-bit target) are queued in a small FIFO. One job
// at a time is presented to the miner on inicio/bloque_bytes/target. The
// dispatcher then waits for terminado or a timeout. The outcome is returned
// as a result record over a valid/ready handshake.

module despachador_minero #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [95:0] job_bloque,
  input  logic [7:0]  job_target,
  output logic        inicio,
  output logic [95:0] bloque_bytes,
  output logic [7:0]  target,
  input  logic        terminado,
  input  logic [23:0] hash,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [23:0] res_hash,
  output logic        res_ok,
  output logic        res_timeout,
  output logic        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = 104;
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Hash passes when its top byte is strictly below the job target (unsigned).
  function automatic logic hash_below_target(input logic [23:0] h, input logic [7:0] t);
    return (h[23:16] < t);
  endfunction

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_full_s, fifo_empty_s;
  logic             push_s, pop_s;
  logic [ENT_W-1:0] head_s;

  // Control and datapath registers
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [95:0]      bloque_q, bloque_d;
  logic [7:0]       target_q, target_d;
  logic [23:0]      res_hash_q, res_hash_d;
  logic             res_ok_q, res_ok_d;
  logic             res_timeout_q, res_timeout_d;
  logic             inicio_q, inicio_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

  assign fifo_full_s  = (count_q == DEPTH_CNT);
  assign fifo_empty_s = (count_q == {(PTR_W + 1){1'b0}});
  assign push_s       = job_valid & ~fifo_full_s;
  assign pop_s        = (state_q == ST_IDLE) & ~fifo_empty_s;
  assign head_s       = mem_q[rd_ptr_q];

  // FIFO next state: write on accepted push, advance read pointer on pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {job_bloque, job_target};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Next-state logic of the dispatch FSM; terminado wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (terminado) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (!terminado) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: load the job on launch, count RUN cycles, capture the outcome.
  always_comb begin
    cnt_d         = cnt_q;
    bloque_d      = bloque_q;
    target_d      = target_q;
    res_hash_d    = res_hash_q;
    res_ok_d      = res_ok_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          bloque_d = head_s[ENT_W-1:8];
          target_d = head_s[7:0];
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (terminado) begin
          res_hash_d    = hash;
          res_ok_d      = hash_below_target(hash, target_q);
          res_timeout_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          res_hash_d    = 24'h000000;
          res_ok_d      = 1'b0;
          res_timeout_d = 1'b1;
        end else begin
          res_hash_d = res_hash_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    inicio_d    = (state_d == ST_RUN);
    res_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE) | (count_d != {(PTR_W + 1){1'b0}});
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO registers; reset discards every queued job.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO payload storage; contents are only meaningful behind count_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Job, result and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= {CNT_W{1'b0}};
      bloque_q      <= 96'h0;
      target_q      <= 8'h00;
      res_hash_q    <= 24'h000000;
      res_ok_q      <= 1'b0;
      res_timeout_q <= 1'b0;
      inicio_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      bloque_q      <= bloque_d;
      target_q      <= target_d;
      res_hash_q    <= res_hash_d;
      res_ok_q      <= res_ok_d;
      res_timeout_q <= res_timeout_d;
      inicio_q      <= inicio_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign job_ready    = ~fifo_full_s;
  assign inicio       = inicio_q;
  assign bloque_bytes = bloque_q;
  assign target       = target_q;
  assign res_valid    = res_valid_q;
  assign res_hash     = res_hash_q;
  assign res_ok       = res_ok_q;
  assign res_timeout  = res_timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_despachador_minero.sv
// Self-checking bench for despachador_minero. A job queue models the FIFO
// contents, and a cycle-counting miner model decides the outcome of each job:
// done, timeout, or coincident. Expected values come from those rules.

module tb_despachador_minero;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int CW    = 5;

  logic        clk;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [95:0] job_bloque;
  logic [7:0]  job_target;
  logic        inicio;
  logic [95:0] bloque_bytes;
  logic [7:0]  target;
  logic        terminado;
  logic [23:0] hash;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_hash;
  logic        res_ok;
  logic        res_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [103:0] exp_q [$];
  logic [7:0]   cur_target;
  logic [95:0]  rb;
  logic [7:0]   rt;
  logic [7:0]   rtop;
  logic [23:0]  rh;

  despachador_minero #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TMO),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_bloque  (job_bloque),
    .job_target  (job_target),
    .inicio      (inicio),
    .bloque_bytes(bloque_bytes),
    .target      (target),
    .terminado   (terminado),
    .hash        (hash),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_hash    (res_hash),
    .res_ok      (res_ok),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the model accepts an offered job when its queue has room.
  task automatic tick();
    logic acc;
    acc = job_valid && (exp_q.size() < DEPTH) && !reset;
    @(posedge clk);
    #1;
    if (acc) begin
      exp_q.push_back({job_bloque, job_target});
      job_valid = 1'b0;
    end
  endtask

  task automatic push_job(input logic [95:0] b, input logic [7:0] t);
    job_bloque = b;
    job_target = t;
    job_valid  = 1'b1;
    for (int i = 0; i < 64 && job_valid; i++) tick();
    check("push_accepted", job_valid, 1'b0);
    job_valid = 1'b0;
  endtask

  // Next edge: either the queue head launches or the dispatcher stays idle.
  task automatic start();
    logic [103:0] j;
    tick();
    if (exp_q.size() > 0) begin
      j = exp_q.pop_front();
      cur_target = j[7:0];
      check("launch_inicio", inicio, 1'b1);
      check("launch_bloque", bloque_bytes, j[103:8]);
      check("launch_target", target, j[7:0]);
      check("launch_busy", busy, 1'b1);
    end else begin
      check("idle_inicio", inicio, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_job_ready", job_ready, 1'b1);
    end
  endtask

  // Miner answers d cycles after inicio; beyond TMO-1 the job times out.
  task automatic serve(input int d, input logic [23:0] h);
    logic to;
    to   = (d > TMO - 1);
    hash = h;
    for (int c = 0; c <= TMO; c++) begin
      terminado = (c >= d);
      tick();
      if ((c == d) || (c == TMO - 1)) break;
      check("run_inicio", inicio, 1'b1);
    end
    check("done_inicio", inicio, 1'b0);
    check("done_valid", res_valid, 1'b1);
    check("done_timeout", res_timeout, to);
    check("done_hash", res_hash, to ? 24'h000000 : h);
    check("done_ok", res_ok, to ? 1'b0 : (h[23:16] < cur_target));
  endtask

  // Accept the result, then keep terminado high for 'hold' DRAIN cycles.
  task automatic ack(input int hold);
    res_ready = 1'b1;
    terminado = (hold > 0);
    tick();
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 1'b0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("drain_hold_inicio", inicio, 1'b0);
    end
    terminado = 1'b0;
    tick();
    check("drain_exit_inicio", inicio, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    job_valid  = 1'b0;
    job_bloque = 96'h0;
    job_target = 8'h00;
    terminado  = 1'b0;
    hash       = 24'h000000;
    res_ready  = 1'b0;
    cur_target = 8'h00;
    tick();
    tick();
    check("rst_inicio", inicio, 1'b0);
    check("rst_bloque", bloque_bytes, 96'h0);
    check("rst_target", target, 8'h00);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_hash", res_hash, 24'h000000);
    check("rst_res_ok", res_ok, 1'b0);
    check("rst_res_timeout", res_timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_job_ready", job_ready, 1'b1);
    reset = 1'b0;

    // Single job with a passing hash, plus launch latency.
    push_job(96'h0102030405060708090A0B0C, 8'h10);
    check("push_lat_inicio", inicio, 1'b0);
    check("push_lat_busy", busy, 1'b1);
    start();
    serve(10, 24'h0FABCD);
    ack(0);
    start();

    // Equal and larger hash bytes fail the strict compare.
    push_job(96'hAAAA, 8'h10);
    start();
    serve(3, 24'h100000);
    ack(0);
    push_job(96'hBBBB, 8'h10);
    start();
    serve(5, 24'hFFFFFF);
    ack(1);
    start();

    // Miner silent: timeout after TMO RUN cycles.
    push_job(96'hCCCC, 8'h80);
    start();
    serve(1000, 24'h123456);
    ack(0);
    start();

    // terminado on the last counter value wins; DRAIN holds off a queued job.
    push_job(96'hDDDD, 8'h80);
    start();
    serve(TMO - 1, 24'h012345);
    push_job(96'hEEEE, 8'h05);
    ack(3);
    start();
    serve(2, 24'h040000);
    ack(0);
    start();

    // Back-pressure: result stalled, FIFO fills, fifth offer waits.
    push_job(96'hA0, 8'h20);
    start();
    serve(4, 24'h1F0000);
    for (int n = 1; n <= 4; n++) push_job(96'hA0 + 96'(n), 8'h20);
    check("full_job_ready", job_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    job_bloque = 96'hA5;
    job_target = 8'h20;
    job_valid  = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("full_refuse", job_ready, 1'b0);
      check("stall_res_valid", res_valid, 1'b1);
    end
    check("fifth_pending", job_valid, 1'b1);
    for (int n = 0; n < 5; n++) begin
      ack(0);
      start();
      serve(n + 1, 24'h210000);
    end
    ack(0);
    start();
    check("fifth_accepted", job_valid, 1'b0);

    // Reset in RUN with two jobs queued.
    push_job(96'hF1, 8'h33);
    start();
    push_job(96'hF2, 8'h33);
    push_job(96'hF3, 8'h33);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_inicio", inicio, 1'b0);
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_job_ready", job_ready, 1'b1);
    check("mid_rst_bloque", bloque_bytes, 96'h0);
    reset = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 5; n++) begin
      tick();
      check("post_rst_inicio", inicio, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end

    // Randomized jobs, delays around the timeout and hashes near the target.
    for (int r = 0; r < 25; r++) begin
      rb = {$urandom, $urandom, $urandom};
      rt = 8'($urandom_range(0, 255));
      push_job(rb, rt);
      start();
      rh = 24'($urandom);
      if (r % 2 == 1) begin
        rtop = rt + 8'($urandom_range(0, 2)) - 8'd1;
        rh[23:16] = rtop;
      end
      serve(int'($urandom_range(0, 20)), rh);
      ack(int'($urandom_range(0, 2)));
      start();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
